// File: rtl/vend_panel_pkg.sv
// Shared constants and helpers for the vending-machine front panel.
// Segment order is {a,b,c,d,e,f,g}, active-high.
package vend_panel_pkg;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic {ST_IDLE, ST_CONV} bcd_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Decimal digits needed for 2^w-1 (log10(2) ~= 0.302).
  function automatic int dec_digits(input int w);
    return (w * 302) / 1000 + 1;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    s = SEG_BLANK;
    if (nib <= 4'd9) s = SEG_DIGIT[nib];
    return s;
  endfunction

endpackage

// File: rtl/vend_panel_if.sv
// Panel-side signal bundle: switches and keys toward the vending FSM, value and 7-seg pins.
interface vend_panel_if #(
  parameter int N_KEYS   = 5,
  parameter int N_DIGITS = 6,
  parameter int VAL_W    = 8
);
  import vend_panel_pkg::*;

  logic [N_KEYS-1:0]   DIP_SW;
  logic [N_KEYS-1:0]   key_pulse;
  logic [N_KEYS-1:0]   key_level;
  logic [VAL_W-1:0]    value;
  logic [N_DIGITS-1:0] dp_mask;
  logic [N_DIGITS-1:0] DIGIT;
  logic [6:0]          SEG;
  logic                SEG_DP;

  modport master (
    output DIP_SW, value, dp_mask,
    input  key_pulse, key_level, DIGIT, SEG, SEG_DP
  );

  modport slave (
    input  DIP_SW, value, dp_mask,
    output key_pulse, key_level, DIGIT, SEG, SEG_DP
  );
endinterface

// File: rtl/vend_key_debounce.sv
// One key channel: polarity normalise, 2-flop synchroniser, tick-sampled history,
// debounced level and a single-cycle press pulse.
module vend_key_debounce
  import vend_panel_pkg::*;
#(
  parameter bit KEY_ACT_LOW = 1'b1,
  parameter int DB_SAMPLES  = 3
) (
  input  logic FPGA_CLK,
  input  logic FPGA_RSTB,
  input  logic tick,
  input  logic sw_raw,
  output logic key_level,
  output logic key_pulse
);

  logic                  sw_norm;
  logic                  sync1_reg, sync2_reg;
  logic [DB_SAMPLES-2:0] hist_reg;
  logic [DB_SAMPLES-1:0] hist_next;
  logic                  level_reg, pulse_reg;

  assign sw_norm   = KEY_ACT_LOW ? ~sw_raw : sw_raw;
  // Window of the last DB_SAMPLES samples including the one taken on this tick.
  assign hist_next = {hist_reg, sync2_reg};

  always_ff @(posedge FPGA_CLK or negedge FPGA_RSTB) begin
    if (!FPGA_RSTB) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      hist_reg  <= '0;
      level_reg <= 1'b0;
      pulse_reg <= 1'b0;
    end else begin
      sync1_reg <= sw_norm;
      sync2_reg <= sync1_reg;
      pulse_reg <= 1'b0;
      if (tick) begin
        hist_reg <= hist_next[DB_SAMPLES-2:0];
        if (&hist_next && !level_reg) begin
          level_reg <= 1'b1;
          pulse_reg <= 1'b1;
        end else if (~|hist_next && level_reg) begin
          level_reg <= 1'b0;
        end
      end
    end
  end

  assign key_level = level_reg;
  assign key_pulse = pulse_reg;

endmodule

// File: rtl/vend_panel_io.sv
// Vending-machine front panel: debounced keys, serial binary-to-BCD conversion and
// a guarded multiplexed 7-seg scan, all clock-enabled from FPGA_CLK.
module vend_panel_io
  import vend_panel_pkg::*;
#(
  parameter int N_KEYS      = 5,
  parameter bit KEY_ACT_LOW = 1'b1,
  parameter int TICK_DIV    = 500000,
  parameter int DB_SAMPLES  = 3,
  parameter int N_DIGITS    = 6,
  parameter int SCAN_DIV    = 50000,
  parameter int VAL_W       = 8
) (
  input  logic         FPGA_CLK,
  input  logic         FPGA_RSTB,
  vend_panel_if.slave  pif
);

  localparam int TICK_W = clog2(TICK_DIV);
  localparam int SCAN_W = clog2(SCAN_DIV);
  localparam int IDX_W  = (N_DIGITS > 1) ? clog2(N_DIGITS) : 1;
  localparam int STEP_W = clog2(VAL_W + 1);
  localparam int CONV_D = (dec_digits(VAL_W) > N_DIGITS) ? dec_digits(VAL_W) : N_DIGITS;
  localparam int BCD_W  = 4 * CONV_D;

  logic [TICK_W-1:0] tick_cnt_reg;
  logic              tick;
  logic [N_KEYS-1:0] key_level_w, key_pulse_w;

  assign tick = (tick_cnt_reg == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge FPGA_CLK or negedge FPGA_RSTB) begin
    if (!FPGA_RSTB) tick_cnt_reg <= '0;
    else            tick_cnt_reg <= tick ? '0 : tick_cnt_reg + TICK_W'(1);
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_KEYS; gi++) begin : g_key
      vend_key_debounce #(
        .KEY_ACT_LOW (KEY_ACT_LOW),
        .DB_SAMPLES  (DB_SAMPLES)
      ) u_key (
        .FPGA_CLK  (FPGA_CLK),
        .FPGA_RSTB (FPGA_RSTB),
        .tick      (tick),
        .sw_raw    (pif.DIP_SW[gi]),
        .key_level (key_level_w[gi]),
        .key_pulse (key_pulse_w[gi])
      );
    end
  endgenerate

  assign pif.key_level = key_level_w;
  assign pif.key_pulse = key_pulse_w;

  bcd_state_t              state_reg, state_next;
  logic                    load, step, done;
  logic [VAL_W-1:0]        shift_reg, conv_value_reg, last_value_reg;
  logic [BCD_W-1:0]        acc_reg, acc_adj, acc_step;
  logic [BCD_W:0]          acc_shift;
  logic [STEP_W-1:0]       step_reg;
  logic [4*N_DIGITS-1:0]   disp_bcd_reg;
  logic                    disp_ovf_reg;
  logic                    ovf;

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (pif.value != last_value_reg) begin
          load       = 1'b1;
          state_next = ST_CONV;
        end
      end
      ST_CONV: begin
        step = 1'b1;
        if (step_reg == STEP_W'(VAL_W - 1)) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge FPGA_CLK or negedge FPGA_RSTB) begin
    if (!FPGA_RSTB) state_reg <= ST_IDLE;
    else            state_reg <= state_next;
  end

  generate
    for (gi = 0; gi < CONV_D; gi++) begin : g_adj
      logic [3:0] nib;
      assign nib = acc_reg[4*gi +: 4];
      assign acc_adj[4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  endgenerate

  assign acc_shift = {acc_adj, shift_reg[VAL_W-1]};
  assign acc_step  = acc_shift[BCD_W-1:0];
  // Any nonzero digit beyond the display width means the value does not fit.
  assign ovf       = |acc_shift[BCD_W:4*N_DIGITS];

  always_ff @(posedge FPGA_CLK or negedge FPGA_RSTB) begin
    if (!FPGA_RSTB) begin
      shift_reg      <= '0;
      conv_value_reg <= '0;
      last_value_reg <= '0;
      acc_reg        <= '0;
      step_reg       <= '0;
      disp_bcd_reg   <= '0;
      disp_ovf_reg   <= 1'b0;
    end else begin
      if (load) begin
        shift_reg      <= pif.value;
        conv_value_reg <= pif.value;
        acc_reg        <= '0;
        step_reg       <= '0;
      end else if (step) begin
        shift_reg <= shift_reg << 1;
        acc_reg   <= acc_step;
        step_reg  <= step_reg + STEP_W'(1);
      end
      // Display and last_value move together so a partial result is never shown.
      if (done) begin
        disp_bcd_reg   <= acc_step[4*N_DIGITS-1:0];
        disp_ovf_reg   <= ovf;
        last_value_reg <= conv_value_reg;
      end
    end
  end

  logic [6:0] dig_pat [N_DIGITS];

  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_pat
      logic shown;
      assign shown = (gi == 0) || (|disp_bcd_reg[4*N_DIGITS-1:4*gi]);
      assign dig_pat[gi] = disp_ovf_reg ? SEG_DASH :
                           (shown ? seg_decode(disp_bcd_reg[4*gi +: 4]) : SEG_BLANK);
    end
  endgenerate

  logic [SCAN_W-1:0]   slot_cnt_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [N_DIGITS-1:0] digit_reg, digit_next;
  logic [6:0]          seg_reg, seg_next;
  logic                dp_reg, dp_next;

  always_comb begin
    digit_next = '1;
    seg_next   = SEG_BLANK;
    dp_next    = 1'b0;
    // Slot cycle 0 stays dark so the previous digit cannot ghost onto the next.
    if (slot_cnt_reg != '0) begin
      digit_next[idx_reg] = 1'b0;
      seg_next            = dig_pat[idx_reg];
      dp_next             = pif.dp_mask[idx_reg];
    end
  end

  always_ff @(posedge FPGA_CLK or negedge FPGA_RSTB) begin
    if (!FPGA_RSTB) begin
      slot_cnt_reg <= '0;
      idx_reg      <= '0;
      digit_reg    <= '1;
      seg_reg      <= SEG_BLANK;
      dp_reg       <= 1'b0;
    end else begin
      digit_reg <= digit_next;
      seg_reg   <= seg_next;
      dp_reg    <= dp_next;
      if (slot_cnt_reg == SCAN_W'(SCAN_DIV - 1)) begin
        slot_cnt_reg <= '0;
        idx_reg      <= (idx_reg == IDX_W'(N_DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
      end else begin
        slot_cnt_reg <= slot_cnt_reg + SCAN_W'(1);
      end
    end
  end

  assign pif.DIGIT  = digit_reg;
  assign pif.SEG    = seg_reg;
  assign pif.SEG_DP = dp_reg;

endmodule
